// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Purpose  : Pipeline hazard controller for the 5-phase CPU
//            (FETCH=0, REG=1, EX=2, MEM=3, WB=4). Keeps a 3-slot scoreboard
//            of in-flight writers (EX/MEM/WB) and produces, per cycle, the
//            per-phase stall vector, bubble/flush controls and the operand
//            forwarding selects for Rn/Rm/Rd.
// Ports    :
//   clk, nreset          clock, asynchronous active-low reset
//   rg_*                 decode fields of the instruction in the REG phase
//   ex_redirect          EX instruction writes PC / is a taken branch
//   dbg_freeze           debugger hold of the whole pipe
//   stall_bits           bit i = 1 holds the phase-i registers
//   bubble_ex            inject a NOP into EX on the next edge
//   flush_fd, flush_rg   squash the FETCH / REG instruction
//   fwd_rn/rm/rd_sel     0 regfile, 1 EX alu_out_d, 2 MEM alu_out_q, 3 WB reg_wd
//   stall_cnt, flush_cnt saturating hazard-stall / redirect counters
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
  parameter int REGAW  = 4,
  parameter int PHASES = 5,
  parameter int PC_IDX = 15,
  parameter int CNTW   = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              rg_valid,
  input  logic [REGAW-1:0]  rg_rn_a,
  input  logic [REGAW-1:0]  rg_rm_a,
  input  logic [REGAW-1:0]  rg_rd_a,
  input  logic              rg_uses_rn,
  input  logic              rg_uses_rm,
  input  logic              rg_uses_rd,
  input  logic              rg_reg_we,
  input  logic              rg_is_load,
  input  logic              rg_sets_flags,
  input  logic              rg_uses_flags,
  input  logic              ex_redirect,
  input  logic              dbg_freeze,
  output logic [PHASES-1:0] stall_bits,
  output logic              bubble_ex,
  output logic              flush_fd,
  output logic              flush_rg,
  output logic [1:0]        fwd_rn_sel,
  output logic [1:0]        fwd_rm_sel,
  output logic [1:0]        fwd_rd_sel,
  output logic [CNTW-1:0]   stall_cnt,
  output logic [CNTW-1:0]   flush_cnt
);

  localparam logic [REGAW-1:0]  c_PC_A      = REGAW'(PC_IDX);
  // A hazard holds only FETCH and REG; EX receives a bubble instead.
  localparam logic [PHASES-1:0] c_STALL_HAZ = {{(PHASES-2){1'b0}}, 2'b11};

  localparam logic [1:0] c_SEL_RF  = 2'd0;
  localparam logic [1:0] c_SEL_EX  = 2'd1;
  localparam logic [1:0] c_SEL_MEM = 2'd2;
  localparam logic [1:0] c_SEL_WB  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic             we;
    logic [REGAW-1:0] wa;
    logic             is_load;
    logic             sets_flags;
  } slot_t;

  localparam slot_t c_SLOT_EMPTY = '0;

  slot_t r_ex, r_mem, r_wb;
  logic [CNTW-1:0] r_stall_cnt;
  logic [CNTW-1:0] r_flush_cnt;

  // ---------------------------------------------------------------------------
  // Source matching and forwarding
  // ---------------------------------------------------------------------------
  function automatic logic f_match(input logic             uses,
                                   input logic [REGAW-1:0] addr,
                                   input slot_t            s);
    return uses && s.valid && s.we && (s.wa == addr) && (addr != c_PC_A);
  endfunction

  logic [REGAW-1:0] w_src_a   [3];
  logic [2:0]       w_src_use;
  logic [1:0]       w_fwd     [3];
  logic             w_load_haz;
  logic             w_flag_haz;
  logic             w_hazard;
  logic             w_m_ex, w_m_mem, w_m_wb;

  always_comb begin
    w_src_a[0] = rg_rn_a;
    w_src_a[1] = rg_rm_a;
    w_src_a[2] = rg_rd_a;
    w_src_use  = {rg_uses_rd, rg_uses_rm, rg_uses_rn} & {3{rg_valid}};
    w_load_haz = 1'b0;
    w_m_ex     = 1'b0;
    w_m_mem    = 1'b0;
    w_m_wb     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w_m_ex  = f_match(w_src_use[i], w_src_a[i], r_ex);
      w_m_mem = f_match(w_src_use[i], w_src_a[i], r_mem);
      w_m_wb  = f_match(w_src_use[i], w_src_a[i], r_wb);
      // Load data only exists once the load reaches WB, so a load in EX or
      // MEM is skipped for forwarding and turns into a stall instead.
      if (w_m_ex && !r_ex.is_load) begin
        w_fwd[i] = c_SEL_EX;
      end else if (w_m_mem && !r_mem.is_load) begin
        w_fwd[i] = c_SEL_MEM;
      end else if (w_m_wb) begin
        w_fwd[i] = c_SEL_WB;
      end else begin
        w_fwd[i] = c_SEL_RF;
      end
      w_load_haz = w_load_haz | (w_m_ex & r_ex.is_load) | (w_m_mem & r_mem.is_load);
    end
  end

  // CPSR is written at the end of MEM, so a flag reader only waits while the
  // flag setter sits in EX.
  assign w_flag_haz = rg_valid & rg_uses_flags & r_ex.valid & r_ex.sets_flags;
  assign w_hazard   = w_load_haz | w_flag_haz;

  // ---------------------------------------------------------------------------
  // Control outputs. Priority: reset > freeze > redirect > hazard > normal.
  // nreset gates the combinational outputs so a reset also masks any
  // freeze/redirect request arriving while the pipe is held in reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_bits = '0;
    bubble_ex  = 1'b0;
    flush_fd   = 1'b0;
    flush_rg   = 1'b0;
    fwd_rn_sel = c_SEL_RF;
    fwd_rm_sel = c_SEL_RF;
    fwd_rd_sel = c_SEL_RF;
    if (nreset) begin
      fwd_rn_sel = w_fwd[0];
      fwd_rm_sel = w_fwd[1];
      fwd_rd_sel = w_fwd[2];
      if (dbg_freeze) begin
        stall_bits = '1;
      end else if (ex_redirect) begin
        bubble_ex = 1'b1;
        flush_fd  = 1'b1;
        flush_rg  = 1'b1;
      end else if (w_hazard) begin
        stall_bits = c_STALL_HAZ;
        bubble_ex  = 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard advance
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_ex  <= c_SLOT_EMPTY;
      r_mem <= c_SLOT_EMPTY;
      r_wb  <= c_SLOT_EMPTY;
    end else if (!dbg_freeze) begin
      r_wb  <= r_mem;
      r_mem <= r_ex;
      if (rg_valid && !w_hazard && !ex_redirect) begin
        r_ex.valid      <= 1'b1;
        r_ex.we         <= rg_reg_we;
        r_ex.wa         <= rg_rd_a;
        r_ex.is_load    <= rg_is_load;
        r_ex.sets_flags <= rg_sets_flags;
      end else begin
        r_ex <= c_SLOT_EMPTY;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (!dbg_freeze) begin
      if (ex_redirect) begin
        if (r_flush_cnt != '1) begin
          r_flush_cnt <= r_flush_cnt + 1'b1;
        end
      end else if (w_hazard) begin
        if (r_stall_cnt != '1) begin
          r_stall_cnt <= r_stall_cnt + 1'b1;
        end
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Purpose  : Directed self-checking bench for hazard_ctrl. A second instance
//            with 3-bit counters shares the stimulus so counter saturation is
//            reached in a handful of stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

  logic        clk;
  logic        nreset;
  logic        rg_valid;
  logic [3:0]  rg_rn_a, rg_rm_a, rg_rd_a;
  logic        rg_uses_rn, rg_uses_rm, rg_uses_rd;
  logic        rg_reg_we, rg_is_load, rg_sets_flags, rg_uses_flags;
  logic        ex_redirect, dbg_freeze;
  logic [4:0]  stall_bits;
  logic        bubble_ex, flush_fd, flush_rg;
  logic [1:0]  fwd_rn_sel, fwd_rm_sel, fwd_rd_sel;
  logic [15:0] stall_cnt, flush_cnt;

  logic [4:0]  s_stall_bits;
  logic        s_bubble_ex, s_flush_fd, s_flush_rg;
  logic [1:0]  s_fwd_rn_sel, s_fwd_rm_sel, s_fwd_rd_sel;
  logic [2:0]  s_stall_cnt, s_flush_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  hazard_ctrl u_dut (
    .clk(clk), .nreset(nreset), .rg_valid(rg_valid),
    .rg_rn_a(rg_rn_a), .rg_rm_a(rg_rm_a), .rg_rd_a(rg_rd_a),
    .rg_uses_rn(rg_uses_rn), .rg_uses_rm(rg_uses_rm), .rg_uses_rd(rg_uses_rd),
    .rg_reg_we(rg_reg_we), .rg_is_load(rg_is_load),
    .rg_sets_flags(rg_sets_flags), .rg_uses_flags(rg_uses_flags),
    .ex_redirect(ex_redirect), .dbg_freeze(dbg_freeze),
    .stall_bits(stall_bits), .bubble_ex(bubble_ex),
    .flush_fd(flush_fd), .flush_rg(flush_rg),
    .fwd_rn_sel(fwd_rn_sel), .fwd_rm_sel(fwd_rm_sel), .fwd_rd_sel(fwd_rd_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_ctrl #(.CNTW(3)) u_dut_sat (
    .clk(clk), .nreset(nreset), .rg_valid(rg_valid),
    .rg_rn_a(rg_rn_a), .rg_rm_a(rg_rm_a), .rg_rd_a(rg_rd_a),
    .rg_uses_rn(rg_uses_rn), .rg_uses_rm(rg_uses_rm), .rg_uses_rd(rg_uses_rd),
    .rg_reg_we(rg_reg_we), .rg_is_load(rg_is_load),
    .rg_sets_flags(rg_sets_flags), .rg_uses_flags(rg_uses_flags),
    .ex_redirect(ex_redirect), .dbg_freeze(dbg_freeze),
    .stall_bits(s_stall_bits), .bubble_ex(s_bubble_ex),
    .flush_fd(s_flush_fd), .flush_rg(s_flush_rg),
    .fwd_rn_sel(s_fwd_rn_sel), .fwd_rm_sel(s_fwd_rm_sel), .fwd_rd_sel(s_fwd_rd_sel),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its end");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // args: valid, rn, rm, rd, uses_rn, uses_rm, uses_rd, we, load, sets_flags, uses_flags
  task automatic set_reg(input logic v, input logic [3:0] rn, input logic [3:0] rm,
                         input logic [3:0] rd, input logic urn, input logic urm,
                         input logic urd, input logic we, input logic ld,
                         input logic sf, input logic uf);
    rg_valid      = v;
    rg_rn_a       = rn;
    rg_rm_a       = rm;
    rg_rd_a       = rd;
    rg_uses_rn    = urn;
    rg_uses_rm    = urm;
    rg_uses_rd    = urd;
    rg_reg_we     = we;
    rg_is_load    = ld;
    rg_sets_flags = sf;
    rg_uses_flags = uf;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_use_round();
    set_reg(1, 0, 0, 4, 0, 0, 0, 1, 1, 0, 0);   // LDR r4
    tick();
    set_reg(1, 4, 4, 5, 1, 1, 0, 1, 0, 0, 0);   // ADD r5,r4,r4
    repeat (3) tick();
  endtask

  initial begin
    nreset      = 1'b0;
    ex_redirect = 1'b1;
    dbg_freeze  = 1'b0;
    set_reg(1, 2, 3, 1, 1, 1, 0, 1, 0, 0, 0);   // ADD r1,r2,r3 held during reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_stall",     32'(stall_bits), 32'h0);
    check("rst_bubble",    32'(bubble_ex),  32'h0);
    check("rst_flush_fd",  32'(flush_fd),   32'h0);
    check("rst_flush_rg",  32'(flush_rg),   32'h0);
    check("rst_stall_cnt", 32'(stall_cnt),  32'h0);
    check("rst_flush_cnt", 32'(flush_cnt),  32'h0);
    tick();
    ex_redirect = 1'b0;
    nreset      = 1'b1;
    tick();                                       // EX <= ADD r1

    // ALU forwarding distances
    set_reg(1, 1, 3, 2, 1, 1, 0, 1, 0, 0, 0);   // SUB r2,r1,r3
    @(negedge clk);
    check("alu_d1_rn",     32'(fwd_rn_sel), 32'h1);
    check("alu_d1_rm",     32'(fwd_rm_sel), 32'h0);
    check("alu_d1_stall",  32'(stall_bits), 32'h0);
    check("alu_d1_bubble", 32'(bubble_ex),  32'h0);
    tick();
    set_reg(1, 1, 0, 7, 1, 0, 0, 1, 0, 0, 0);   // r7 <- r1
    @(negedge clk);
    check("alu_d2_rn", 32'(fwd_rn_sel), 32'h2);
    tick();
    set_reg(1, 1, 0, 2, 1, 0, 1, 0, 0, 0, 0);   // STR r2,[r1]
    @(negedge clk);
    check("alu_d3_rn", 32'(fwd_rn_sel), 32'h3);
    check("alu_rd_mem", 32'(fwd_rd_sel), 32'h2);
    tick();
    set_reg(1, 1, 2, 9, 1, 1, 0, 1, 0, 0, 0);   // r9 <- r1,r2
    @(negedge clk);
    check("alu_d4_rn", 32'(fwd_rn_sel), 32'h0);
    check("alu_rm_wb", 32'(fwd_rm_sel), 32'h3);
    tick();
    set_reg(1, 7, 9, 4, 1, 1, 0, 1, 1, 0, 0);   // LDR r4,[r7,r9]
    @(negedge clk);
    check("ldr_rn_wb", 32'(fwd_rn_sel), 32'h3);
    check("ldr_rm_ex", 32'(fwd_rm_sel), 32'h1);
    tick();

    // Load-use: two stall cycles, then forward from WB
    set_reg(1, 4, 4, 5, 1, 1, 0, 1, 0, 0, 0);   // ADD r5,r4,r4
    @(negedge clk);
    check("lu1_stall",  32'(stall_bits), 32'h3);
    check("lu1_bubble", 32'(bubble_ex),  32'h1);
    check("lu1_flush",  32'(flush_fd),   32'h0);
    check("lu1_rn",     32'(fwd_rn_sel), 32'h0);
    tick();
    @(negedge clk);
    check("lu2_stall",  32'(stall_bits), 32'h3);
    check("lu2_bubble", 32'(bubble_ex),  32'h1);
    tick();
    @(negedge clk);
    check("lu3_stall",  32'(stall_bits), 32'h0);
    check("lu3_bubble", 32'(bubble_ex),  32'h0);
    check("lu3_rn",     32'(fwd_rn_sel), 32'h3);
    check("lu3_rm",     32'(fwd_rm_sel), 32'h3);
    check("lu_stall_cnt", 32'(stall_cnt), 32'h2);
    tick();

    // Flags: CMP then ADDEQ -> one stall; CMP, NOP, ADDEQ -> none
    set_reg(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // CMP
    tick();
    set_reg(1, 0, 0, 10, 0, 0, 0, 1, 0, 0, 1);  // ADDEQ r10
    @(negedge clk);
    check("flg1_stall", 32'(stall_bits), 32'h3);
    tick();
    @(negedge clk);
    check("flg2_stall", 32'(stall_bits), 32'h0);
    check("flg_stall_cnt", 32'(stall_cnt), 32'h3);
    tick();
    set_reg(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // CMP
    tick();
    set_reg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);   // NOP
    tick();
    set_reg(1, 0, 0, 10, 0, 0, 0, 1, 0, 0, 1);  // ADDEQ r10
    @(negedge clk);
    check("flg_gap_stall", 32'(stall_bits), 32'h0);
    tick();

    // Redirect overriding a load-use match
    set_reg(1, 0, 0, 4, 0, 0, 0, 1, 1, 0, 0);   // LDR r4
    tick();
    set_reg(1, 4, 4, 5, 1, 1, 0, 1, 0, 0, 0);
    ex_redirect = 1'b1;
    @(negedge clk);
    check("rdr_stall",    32'(stall_bits), 32'h0);
    check("rdr_flush_fd", 32'(flush_fd),   32'h1);
    check("rdr_flush_rg", 32'(flush_rg),   32'h1);
    check("rdr_bubble",   32'(bubble_ex),  32'h1);
    tick();
    ex_redirect = 1'b0;
    set_reg(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("rdr_flush_cnt", 32'(flush_cnt), 32'h1);
    check("rdr_stall_cnt", 32'(stall_cnt), 32'h3);
    check("rdr_flush_off", 32'(flush_fd),  32'h0);
    tick();

    // PC source is never forwarded
    set_reg(1, 0, 0, 15, 0, 0, 0, 1, 0, 0, 0);  // MOV r15
    tick();
    set_reg(1, 15, 0, 11, 1, 0, 0, 1, 0, 0, 0); // ADD r11,r15
    @(negedge clk);
    check("pc_rn", 32'(fwd_rn_sel), 32'h0);
    tick();

    // Freeze 3 cycles (redirect requested meanwhile is ignored)
    set_reg(1, 11, 0, 12, 1, 0, 0, 1, 0, 0, 0); // r12 <- r11
    dbg_freeze  = 1'b1;
    ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("frz_stall",  32'(stall_bits), 32'h1F);
      check("frz_bubble", 32'(bubble_ex),  32'h0);
      check("frz_flush",  32'(flush_rg),   32'h0);
      check("frz_rn",     32'(fwd_rn_sel), 32'h1);
      tick();
    end
    dbg_freeze  = 1'b0;
    ex_redirect = 1'b0;
    @(negedge clk);
    check("post_frz_rn",    32'(fwd_rn_sel), 32'h1);
    check("post_frz_flush", 32'(flush_cnt),  32'h1);
    check("post_frz_stall", 32'(stall_bits), 32'h0);
    tick();
    set_reg(1, 11, 0, 13, 1, 0, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("post_frz_rn2", 32'(fwd_rn_sel), 32'h2);
    tick();

    // Counter saturation on the 3-bit instance
    load_use_round();
    load_use_round();
    @(negedge clk);
    check("sat_small_7",  32'(s_stall_cnt), 32'h7);
    check("sat_main_7",   32'(stall_cnt),   32'h7);
    tick();
    load_use_round();
    @(negedge clk);
    check("sat_small_hold", 32'(s_stall_cnt), 32'h7);
    check("sat_main_9",     32'(stall_cnt),   32'h9);
    tick();

    // Reset in the middle of a stall
    set_reg(1, 0, 0, 4, 0, 0, 0, 1, 1, 0, 0);   // LDR r4
    tick();
    set_reg(1, 4, 4, 5, 1, 1, 0, 1, 0, 0, 0);
    @(negedge clk);
    check("mid_pre_stall", 32'(stall_bits), 32'h3);
    #1;
    nreset = 1'b0;
    #1;
    check("mid_rst_stall",  32'(stall_bits), 32'h0);
    check("mid_rst_bubble", 32'(bubble_ex),  32'h0);
    check("mid_rst_scnt",   32'(stall_cnt),  32'h0);
    check("mid_rst_fcnt",   32'(flush_cnt),  32'h0);
    tick();
    nreset = 1'b1;
    @(negedge clk);
    check("mid_rel_stall", 32'(stall_bits), 32'h0);
    check("mid_rel_rn",    32'(fwd_rn_sel), 32'h0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
